// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture path.
// Holds the active-high glyph encodings (bit 6..0 = a..g), the blank pattern,
// record field widths and the capture FSM state type.
package seg7_pkg;

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned PAIR_W  = 2 * SEG_W;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
   localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
   localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
   localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
   localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
   localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
   localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
   localparam logic [SEG_W-1:0] SEG_A = 7'h77;
   localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
   localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
   localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
   localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_F = 7'h47;

   typedef enum logic {
      StIdle = 1'b0,
      StFull = 1'b1
   } cap_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment glyph decoder.
//   seg_i   : active-high segment pattern, bit 6..0 = a..g
//   digit_o : decoded hex value, 0 when blank or unrecognised
//   blank_o : pattern was all segments off
//   error_o : pattern is neither blank nor a legal hex glyph
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0]   seg_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               blank_o,
   output logic               error_o
);

   always_comb begin
      digit_o = '0;
      blank_o = 1'b0;
      error_o = 1'b0;
      case (seg_i)
         SEG_BLANK: blank_o = 1'b1;
         SEG_0:     digit_o = 4'h0;
         SEG_1:     digit_o = 4'h1;
         SEG_2:     digit_o = 4'h2;
         SEG_3:     digit_o = 4'h3;
         SEG_4:     digit_o = 4'h4;
         SEG_5:     digit_o = 4'h5;
         SEG_6:     digit_o = 4'h6;
         SEG_7:     digit_o = 4'h7;
         SEG_8:     digit_o = 4'h8;
         SEG_9:     digit_o = 4'h9;
         SEG_A:     digit_o = 4'hA;
         SEG_B:     digit_o = 4'hB;
         SEG_C:     digit_o = 4'hC;
         SEG_D:     digit_o = 4'hD;
         SEG_E:     digit_o = 4'hE;
         SEG_F:     digit_o = 4'hF;
         default:   error_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// Seven-segment loop-back capture.
// Samples a left/right segment pair, waits for it to hold steady for
// STABLE_CYCLES clocks, decodes both glyphs and offers the record on a
// valid/ready handshake. Each distinct steady pair is reported once.
//   clock, reset     : clock and asynchronous active-low reset
//   Enable           : capture active; low holds the stability counter at 0
//   Seg_L, Seg_R     : active-high segment buses (bit 6..0 = a..g)
//   Ready / Valid    : record handshake
//   Digit_*, Blank_* : decoded digits and blank flags
//   Error            : at least one pattern was not a legal glyph
//   Overrun          : a capture was dropped while this record waited
module seven_seg_capture
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               Enable,
   input  logic [SEG_W-1:0]   Seg_L,
   input  logic [SEG_W-1:0]   Seg_R,
   input  logic               Ready,
   output logic               Valid,
   output logic [DIGIT_W-1:0] Digit_L,
   output logic [DIGIT_W-1:0] Digit_R,
   output logic               Blank_L,
   output logic               Blank_R,
   output logic               Error,
   output logic               Overrun
);

   localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

   logic [PAIR_W-1:0]  pair_in;
   logic [PAIR_W-1:0]  samp_q, samp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PAIR_W-1:0]  last_q, last_d;
   logic               have_last_q, have_last_d;
   cap_state_e         state_q, state_d;
   logic [DIGIT_W-1:0] digit_l_q, digit_l_d, digit_r_q, digit_r_d;
   logic               blank_l_q, blank_l_d, blank_r_q, blank_r_d;
   logic               error_q, error_d, overrun_q, overrun_d;

   logic [DIGIT_W-1:0] dec_digit_l, dec_digit_r;
   logic               dec_blank_l, dec_blank_r, dec_err_l, dec_err_r;
   logic               same, capture, handshake;

   assign pair_in = {Seg_L, Seg_R};

   // Decode the registered sample so outputs never see raw inputs.
   seg7_to_hex u_dec_l (
      .seg_i   (samp_q[PAIR_W-1:SEG_W]),
      .digit_o (dec_digit_l),
      .blank_o (dec_blank_l),
      .error_o (dec_err_l)
   );

   seg7_to_hex u_dec_r (
      .seg_i   (samp_q[SEG_W-1:0]),
      .digit_o (dec_digit_r),
      .blank_o (dec_blank_r),
      .error_o (dec_err_r)
   );

   always_comb begin
      samp_d      = pair_in;
      cnt_d       = cnt_q;
      last_d      = last_q;
      have_last_d = have_last_q;
      state_d     = state_q;
      digit_l_d   = digit_l_q;
      digit_r_d   = digit_r_q;
      blank_l_d   = blank_l_q;
      blank_r_d   = blank_r_q;
      error_d     = error_q;
      overrun_d   = overrun_q;

      same      = (pair_in == samp_q);
      handshake = (state_q == StFull) && Ready;
      // cnt_q == STABLE_CYCLES-1 means this edge is the STABLE_CYCLES-th
      // consecutive edge on which the pair has matched the sample.
      capture   = Enable && same && (cnt_q == CNT_HIT) &&
                  (!have_last_q || (samp_q != last_q));

      if (!Enable || !same) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // The pair counts as reported even when it is dropped as an overrun.
      if (capture) begin
         last_d      = samp_q;
         have_last_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (capture) begin
               state_d   = StFull;
               digit_l_d = dec_digit_l;
               digit_r_d = dec_digit_r;
               blank_l_d = dec_blank_l;
               blank_r_d = dec_blank_r;
               error_d   = dec_err_l | dec_err_r;
               overrun_d = 1'b0;
            end
         end
         StFull: begin
            if (handshake) begin
               overrun_d = 1'b0;
               if (capture) begin
                  digit_l_d = dec_digit_l;
                  digit_r_d = dec_digit_r;
                  blank_l_d = dec_blank_l;
                  blank_r_d = dec_blank_r;
                  error_d   = dec_err_l | dec_err_r;
               end else begin
                  state_d = StIdle;
               end
            end else if (capture) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         samp_q      <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         have_last_q <= 1'b0;
         state_q     <= StIdle;
         digit_l_q   <= '0;
         digit_r_q   <= '0;
         blank_l_q   <= 1'b0;
         blank_r_q   <= 1'b0;
         error_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         samp_q      <= samp_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         have_last_q <= have_last_d;
         state_q     <= state_d;
         digit_l_q   <= digit_l_d;
         digit_r_q   <= digit_r_d;
         blank_l_q   <= blank_l_d;
         blank_r_q   <= blank_r_d;
         error_q     <= error_d;
         overrun_q   <= overrun_d;
      end
   end

   assign Valid   = (state_q == StFull);
   assign Digit_L = digit_l_q;
   assign Digit_R = digit_r_q;
   assign Blank_L = blank_l_q;
   assign Blank_R = blank_r_q;
   assign Error   = error_q;
   assign Overrun = overrun_q;

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side counterpart of the latched dual seven-segment display driver. It samples a pair of active-high segment buses (left/right digit) and waits for both to hold steady for a programmable number of clocks. It then decodes each pattern back to a 4-bit hex digit plus blank/error flags and presents the result on a valid/ready handshake. It sits in display loop-back and self-check paths, downstream of the display driver outputs.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive unchanged samples required before capture; legal range 1..255.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Enable  in  1  high = capture active; low = stability counter held at 0, no new captures.
- Seg_L  in  7  left segment pattern, bit 6..0 = a,b,c,d,e,f,g, active-high.
- Seg_R  in  7  right segment pattern, same encoding.
- Ready  in  1  consumer accepts the record when Valid && Ready at a rising edge.
- Valid  out  1  captured record available.
- Digit_L, Digit_R  out  4  decoded hex value; 0 when blank or error.
- Blank_L, Blank_R  out  1  pattern was 7'h00.
- Error  out  1  at least one pattern was neither blank nor a legal hex glyph.
- Overrun  out  1  at least one capture was dropped while this record waited.

## Operation
- Legal glyphs (hex): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47; blank=00. Any other value sets Error. The affected digit reads 0 with Blank=0.
- Sample stage: {Seg_L,Seg_R} is registered into S every edge.
- Stability counter cnt:
  - Cleared to 0 when the incoming pair differs from S, or when Enable=0.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture condition: Enable=1, cnt==STABLE_CYCLES-1, incoming pair == S, and S differs from the last captured pair (or nothing has been captured since reset).
- Capture with Valid=0: the output record loads the decoded values, Valid goes to 1, and S becomes the last captured pair.
- Capture with Valid=1 and no handshake this edge: the new data is dropped, Overrun is set, and S still becomes the last captured pair.
- Capture on the same edge as a handshake (Valid && Ready): the new record loads, Valid stays 1, and Overrun clears.
- Handshake with no capture: Valid goes to 0 and Overrun clears.
- Output record fields are stable while Valid=1 and not accepted.
- Two-state FSM:
  - IDLE (Valid=0) -> FULL on capture.
  - FULL -> IDLE on handshake without capture.
  - FULL -> FULL on handshake with capture.
- A steady pair is reported exactly once. Re-reporting requires a different stable pair.

## Timing
- Reset (reset=0): S=0, cnt=0, no last pair, Valid=0, all Digit/Blank/Error/Overrun=0. Reset assertion mid-record discards the record immediately.
- Latency: if inputs change just before edge E0 and then hold, Valid rises at edge E0+STABLE_CYCLES. With STABLE_CYCLES=1, that is the edge after E0.
- A glitch shorter than STABLE_CYCLES+1 edges is never captured. The counter restarts from the glitch.
- Enable deassert mid-count: cnt returns to 0. Counting resumes from 0 on the first enabled edge.
- Enable does not affect an already-held record or the handshake.
- Ready is ignored while Valid=0.
- No combinational path from any input to any output.

## Structure
- Package seg7_pkg holds the 16 glyph constants, SEG_BLANK=7'h00, and the record fields' widths.
- Sub-module seg7_to_hex is purely combinational and instantiated twice: 7-bit pattern -> {digit[3:0], blank, error}.
- Top holds the sample register, counter (width $clog2(STABLE_CYCLES+1)), last-pair register plus its have-last bit, FSM, and output record.

## Test plan
- After reset, hold Seg_L=7E, Seg_R=30, Enable=1, Ready=0, STABLE_CYCLES=4 -> Valid rises on the 4th edge after S loads; Digit_L=0, Digit_R=1, Blank=0, Error=0; no second capture while the inputs stay put.
- Hold a valid record, then present 77/1F stable for 6 cycles -> the record stays at 0/1 and Overrun=1. Pulse Ready -> Valid=0 and Overrun=0 on that edge; 77/1F is not re-reported.
- Toggle Seg_L between 6D and 79 every 3 cycles with STABLE_CYCLES=4 -> Valid never rises.
- Seg_L=00, Seg_R=12 stable -> Blank_L=1, Digit_L=0, Error=1, Digit_R=0.
- Ready held 1 while a new stable pair completes on the handshake edge -> Valid stays 1 and the record updates to the new digits.
- Assert reset during a FULL state and during counting -> all outputs 0 immediately. After release, the same steady pair is captured again after STABLE_CYCLES edges.
